instruction_fetch_register: RTL and testbench
=============================================

INSTRUCTION_FETCH_REGISTER -- requirements
Module: instruction_fetch_register

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, meaning the width of one input beat in bits.
REQ-002 The block SHALL have parameter SLOTS, default 2, meaning beats per instruction word (legal range 1..8).
REQ-003 The block SHALL have derived parameter IR_W = IN_W*SLOTS, not overridable, meaning the instruction word width.
REQ-004 The block SHALL have port Clock  input  1  single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port I  input  IN_W  beat data.
REQ-007 The block SHALL have port Write  input  1  beat strobe.
REQ-008 The block SHALL have port Ready  output  1  beat accepted this cycle if Write=1.
REQ-009 The block SHALL have port Flush  input  1  discard the partially assembled word.
REQ-010 The block SHALL have port IROut  output  IR_W  completed instruction word.
REQ-011 The block SHALL have port Valid  output  1  IROut holds an unconsumed word.
REQ-012 The block SHALL have port Take  input  1  consumer acknowledge of IROut.
REQ-013 The block SHALL have port SlotPtr  output  max(1,clog2(SLOTS))  next slot to be filled.

Function
REQ-014 An accepted beat SHALL be a cycle with Write=1 and Ready=1 and Flush=0.
REQ-015 Accepted beats SHALL fill slots in ascending order: slot k occupies bits [k*IN_W +: IN_W]; the first beat after reset/flush/completion goes to slot 0 (LSB).
REQ-016 Each accepted beat SHALL increment SlotPtr by 1; an accepted beat at SlotPtr=SLOTS-1 SHALL complete the word and wrap SlotPtr to 0.
REQ-017 On completion the assembled word including the completing beat SHALL be written to IROut and Valid set to 1 at the same edge (one-cycle latency from the final beat).
REQ-018 Ready SHALL be combinational: Ready = NOT(SlotPtr=SLOTS-1 AND Valid=1 AND Take=0); non-final beats are always accepted.
REQ-019 Take=1 with Valid=1 SHALL clear Valid at the edge, unless a completion occurs the same edge, in which case IROut takes the new word and Valid stays 1.
REQ-020 Take=1 with Valid=0 SHALL be ignored.
REQ-021 Write=1 with Ready=0 SHALL be dropped with no state change; the producer must hold the beat.
REQ-022 Flush=1 SHALL reset SlotPtr to 0 and zero the assembly slots; a same-cycle Write is dropped; IROut and Valid are unaffected; Take is still honoured.
REQ-023 With SLOTS=1 every accepted beat SHALL complete a word; SlotPtr stays 0.
REQ-024 IROut SHALL hold its value until the next completion; it is not cleared by Take.

Reset
REQ-025 When Reset=0 at a rising edge, IROut SHALL become 0, Valid 0, SlotPtr 0 and all assembly slots 0, overriding Write, Flush and Take.
REQ-026 Reset mid-assembly SHALL discard the partial word; the first accepted beat after Reset returns to 1 goes to slot 0.

Configuration
REQ-027 Macro IR_DIRECT_WRITE_EN, when defined, SHALL add inputs Direct (1 bit) and Sel (SlotPtr width).
REQ-028 With IR_DIRECT_WRITE_EN, Write=1 and Direct=1 SHALL write I into slot Sel of IROut directly, always accepted regardless of Ready, with SlotPtr, Valid and assembly slots unchanged; Sel>=SLOTS is ignored.
REQ-029 With IR_DIRECT_WRITE_EN, Direct=1 beats SHALL NOT count as accepted assembly beats; Reset still overrides.
REQ-030 Without IR_DIRECT_WRITE_EN, Direct and Sel SHALL not exist and behaviour is REQ-014..REQ-026 only.

Verification (IN_W=8, SLOTS=2 unless stated)
REQ-031 Reset, Write 0x34 then 0x12 on consecutive cycles -> after 2nd edge IROut=0x1234, Valid=1, SlotPtr=0.
REQ-032 Valid=1 held, Write 0xCD (accepted, SlotPtr=1), Write 0xAB with Take=0 -> Ready=0, no change; then Write 0xAB with Take=1 -> IROut=0xABCD, Valid=1.
REQ-033 Write 0x55, Flush, then Write 0x11, 0x22 -> IROut=0x2211; 0x55 never appears; Flush+Write same cycle -> beat dropped, SlotPtr=0.
REQ-034 Write 0x77, Reset=0 one cycle, Write 0x88, 0x99 -> IROut=0x9988, Valid=0 during reset cycle then 1.
REQ-035 SLOTS=4: Write 0x01,0x02,0x03,0x04 -> IROut=0x04030201 after 4th edge; SlotPtr sequence 1,2,3,0.
REQ-036 IR_DIRECT_WRITE_EN defined, IROut=0x1234: Direct=1 Sel=1 I=0xEE -> IROut=0xEE34, Valid and SlotPtr unchanged.

Source files
------------

// File: rtl/instruction_fetch_register.sv
// instruction_fetch_register
// Assembles SLOTS narrow beats of IN_W bits into one IR_W-bit instruction
// word. Beats fill slot 0 (LSB) upward. The completed word is presented on
// IROut with a Valid flag until the consumer acknowledges it with Take.
// Ready stalls only the word-completing beat while an unconsumed word is
// still waiting.
//
// Optional feature: define IR_DIRECT_WRITE_EN to add the Direct/Sel inputs.
// A Direct beat patches one slot of IROut in place. It bypasses the
// assembly path and ignores Ready. Without the macro the block is a plain
// assembler.
//
// Reset is synchronous and active-low. It clears everything, including
// IROut.

module instruction_fetch_register #(
  parameter  int IN_W  = 8,
  parameter  int SLOTS = 2,
  localparam int IR_W  = IN_W * SLOTS,
  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [IN_W-1:0]  I,
  input  logic             Write,
  output logic             Ready,
  input  logic             Flush,
  output logic [IR_W-1:0]  IROut,
  output logic             Valid,
  input  logic             Take,
  output logic [PTR_W-1:0] SlotPtr
`ifdef IR_DIRECT_WRITE_EN
  ,
  input  logic             Direct,
  input  logic [PTR_W-1:0] Sel
`endif
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

  // Registered state.
  logic [PTR_W-1:0] ptr_q;
  logic [IR_W-1:0]  asm_q;
  logic [IR_W-1:0]  ir_q;
  logic             valid_q;

  // Next-state values.
  logic [PTR_W-1:0] ptr_d;
  logic [IR_W-1:0]  asm_d;
  logic [IR_W-1:0]  ir_d;
  logic             valid_d;

  // Datapath and handshake terms.
  logic             last_slot;
  logic             ready_int;
  logic             direct_beat;
  logic             accept;
  logic [IR_W-1:0]  merged_word;

`ifdef IR_DIRECT_WRITE_EN
  assign direct_beat = Write && Direct;
`else
  assign direct_beat = 1'b0;
`endif

  // The final beat stalls only if the previous word is still unconsumed and
  // is not being taken this cycle.
  assign last_slot = (ptr_q == LAST_SLOT);
  assign ready_int = !(last_slot && valid_q && !Take);

  // Direct patches never count as assembly beats. A flush drops any beat
  // offered in the same cycle.
  assign accept = Write && ready_int && !Flush && !direct_beat;

  // The partial word with the incoming beat dropped into the current slot.
  // On completion this becomes the new IROut value.
  always_comb begin
    merged_word = asm_q;
    for (int k = 0; k < SLOTS; k++) begin
      if (ptr_q == PTR_W'(k)) begin
        merged_word[k*IN_W +: IN_W] = I;
      end
    end
  end

  // Next-state logic for the slot pointer, assembly buffer, IROut and Valid.
  always_comb begin
    ptr_d   = ptr_q;
    asm_d   = asm_q;
    ir_d    = ir_q;
    valid_d = valid_q;

    // The consumer acknowledge is honoured even during a flush.
    // A completion later in this block overrides it.
    if (Take && valid_q) begin
      valid_d = 1'b0;
    end

    if (Flush) begin
      ptr_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (last_slot) begin
        ir_d    = merged_word;
        valid_d = 1'b1;
        ptr_d   = '0;
        asm_d   = '0;
      end else begin
        asm_d = merged_word;
        ptr_d = ptr_q + PTR_W'(1);
      end
    end

`ifdef IR_DIRECT_WRITE_EN
    // In-place patch of one IROut slot. A Sel value outside the slot range
    // matches nothing and is ignored.
    if (direct_beat) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (Sel == PTR_W'(k)) begin
          ir_d[k*IN_W +: IN_W] = I;
        end
      end
    end
`endif
  end

  // State register. Reset is synchronous, active-low, and overrides
  // everything else.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ptr_q   <= '0;
      asm_q   <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      asm_q   <= asm_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign Ready   = ready_int;
  assign IROut   = ir_q;
  assign Valid   = valid_q;
  assign SlotPtr = ptr_q;

endmodule

// File: tb/tb_instruction_fetch_register.sv
// tb_instruction_fetch_register
// Vector table against the default IN_W=8 / SLOTS=2 instance, plus short
// hand-written sequences for the SLOTS=4 and SLOTS=1 instances.
// Optional Direct-write sequence when IR_DIRECT_WRITE_EN is defined.

module tb_instruction_fetch_register;

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [7:0]  din;
    logic        fl;
    logic        tk;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [15:0] exp_ir;
    logic        exp_v;
    logic        exp_ptr;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        v;
    logic [2:0]  ptr;
  } exp_t;

  localparam int NVEC = 23;

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Default instance: SLOTS=2.
  logic        Reset = 1'b0;
  logic [7:0]  I = '0;
  logic        Write = 1'b0;
  logic        Flush = 1'b0;
  logic        Take = 1'b0;
  logic        Ready;
  logic [15:0] IROut;
  logic        Valid;
  logic [0:0]  SlotPtr;
`ifdef IR_DIRECT_WRITE_EN
  logic        Direct = 1'b0;
  logic [0:0]  Sel = '0;
`endif

  // SLOTS=4 instance.
  logic        Reset4 = 1'b0;
  logic [7:0]  I4 = '0;
  logic        Write4 = 1'b0;
  logic        Ready4;
  logic [31:0] IROut4;
  logic        Valid4;
  logic [1:0]  SlotPtr4;

  // SLOTS=1 instance.
  logic        Reset1 = 1'b0;
  logic [7:0]  I1 = '0;
  logic        Write1 = 1'b0;
  logic        Take1 = 1'b0;
  logic        Ready1;
  logic [7:0]  IROut1;
  logic        Valid1;
  logic [0:0]  SlotPtr1;

  logic        zero = 1'b0;
`ifdef IR_DIRECT_WRITE_EN
  logic [1:0]  sel4 = '0;
  logic [0:0]  sel1 = '0;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  vec_t vecs[NVEC];

  instruction_fetch_register #(.IN_W(8), .SLOTS(2)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .Write(Write), .Ready(Ready),
    .Flush(Flush), .IROut(IROut), .Valid(Valid), .Take(Take),
    .SlotPtr(SlotPtr)
`ifdef IR_DIRECT_WRITE_EN
    , .Direct(Direct), .Sel(Sel)
`endif
  );

  instruction_fetch_register #(.IN_W(8), .SLOTS(4)) dut4 (
    .Clock(Clock), .Reset(Reset4), .I(I4), .Write(Write4), .Ready(Ready4),
    .Flush(zero), .IROut(IROut4), .Valid(Valid4), .Take(zero),
    .SlotPtr(SlotPtr4)
`ifdef IR_DIRECT_WRITE_EN
    , .Direct(zero), .Sel(sel4)
`endif
  );

  instruction_fetch_register #(.IN_W(8), .SLOTS(1)) dut1 (
    .Clock(Clock), .Reset(Reset1), .I(I1), .Write(Write1), .Ready(Ready1),
    .Flush(zero), .IROut(IROut1), .Valid(Valid1), .Take(Take1),
    .SlotPtr(SlotPtr1)
`ifdef IR_DIRECT_WRITE_EN
    , .Direct(zero), .Sel(sel1)
`endif
  );

  // Single comparison.
  // Every failure prints one line and increments the error count.
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the given outputs.
  task automatic checkOutput(input logic [31:0] act_ir, input logic act_v,
                             input logic [2:0] act_ptr);
    exp_t e;
    if (sbq.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sbq.pop_front();
      check({e.name, "_ir"},    act_ir,       e.ir);
      check({e.name, "_valid"}, 32'(act_v),   32'(e.v));
      check({e.name, "_ptr"},   32'(act_ptr), 32'(e.ptr));
    end
  endtask

  function automatic vec_t mk(input logic rst_n, input logic wr,
                              input logic [7:0] din, input logic fl,
                              input logic tk, input logic chk_rdy,
                              input logic exp_rdy, input logic [15:0] exp_ir,
                              input logic exp_v, input logic exp_ptr);
    vec_t v;
    v.rst_n   = rst_n;
    v.wr      = wr;
    v.din     = din;
    v.fl      = fl;
    v.tk      = tk;
    v.chk_rdy = chk_rdy;
    v.exp_rdy = exp_rdy;
    v.exp_ir  = exp_ir;
    v.exp_v   = exp_v;
    v.exp_ptr = exp_ptr;
    return v;
  endfunction

  // Drive one vector on the falling edge and check the combinational Ready.
  // Queue the expected post-edge state, then compare just after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(negedge Clock);
    Reset = v.rst_n;
    Write = v.wr;
    I     = v.din;
    Flush = v.fl;
    Take  = v.tk;
    #1;
    if (v.chk_rdy) check($sformatf("v%0d_ready", idx), 32'(Ready), 32'(v.exp_rdy));
    e.name = $sformatf("v%0d", idx);
    e.ir   = 32'(v.exp_ir);
    e.v    = v.exp_v;
    e.ptr  = 3'(v.exp_ptr);
    sbq.push_back(e);
    @(posedge Clock);
    #1;
    checkOutput(32'(IROut), Valid, 3'(SlotPtr));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    //                rst wr din   fl tk chk rdy exp_ir   v  ptr
    vecs[0]  = mk(0, 1, 8'hAA, 1, 1, 0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(1, 1, 8'h34, 0, 0, 1, 1, 16'h0000, 0, 1);
    vecs[2]  = mk(1, 1, 8'h12, 0, 0, 1, 1, 16'h1234, 1, 0);
    vecs[3]  = mk(1, 1, 8'hCD, 0, 0, 1, 1, 16'h1234, 1, 1);
    vecs[4]  = mk(1, 1, 8'hAB, 0, 0, 1, 0, 16'h1234, 1, 1);
    vecs[5]  = mk(1, 1, 8'hAB, 0, 1, 1, 1, 16'hABCD, 1, 0);
    vecs[6]  = mk(1, 0, 8'h00, 0, 1, 1, 1, 16'hABCD, 0, 0);
    vecs[7]  = mk(1, 0, 8'h00, 0, 1, 1, 1, 16'hABCD, 0, 0);
    vecs[8]  = mk(1, 1, 8'h55, 0, 0, 1, 1, 16'hABCD, 0, 1);
    vecs[9]  = mk(1, 0, 8'h00, 1, 0, 1, 1, 16'hABCD, 0, 0);
    vecs[10] = mk(1, 1, 8'h11, 0, 0, 1, 1, 16'hABCD, 0, 1);
    vecs[11] = mk(1, 1, 8'h22, 0, 0, 1, 1, 16'h2211, 1, 0);
    vecs[12] = mk(1, 1, 8'h99, 1, 0, 1, 1, 16'h2211, 1, 0);
    vecs[13] = mk(1, 1, 8'h66, 0, 0, 1, 1, 16'h2211, 1, 1);
    vecs[14] = mk(1, 0, 8'h00, 1, 1, 1, 1, 16'h2211, 0, 0);
    vecs[15] = mk(1, 1, 8'h77, 0, 0, 1, 1, 16'h2211, 0, 1);
    vecs[16] = mk(0, 1, 8'h88, 0, 0, 1, 1, 16'h0000, 0, 0);
    vecs[17] = mk(1, 1, 8'h88, 0, 0, 1, 1, 16'h0000, 0, 1);
    vecs[18] = mk(1, 1, 8'h99, 0, 0, 1, 1, 16'h9988, 1, 0);
    vecs[19] = mk(1, 1, 8'h01, 0, 0, 1, 1, 16'h9988, 1, 1);
    vecs[20] = mk(1, 1, 8'h02, 1, 0, 1, 0, 16'h9988, 1, 0);
    vecs[21] = mk(1, 1, 8'h03, 0, 0, 1, 1, 16'h9988, 1, 1);
    vecs[22] = mk(1, 1, 8'h04, 0, 1, 1, 1, 16'h0403, 1, 0);

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

`ifdef IR_DIRECT_WRITE_EN
    // Patch slot 1 of a valid word; Valid and SlotPtr stay put.
    @(negedge Clock);
    Write = 1'b1; Direct = 1'b1; Sel = 1'b1; I = 8'hEE; Take = 1'b0; Flush = 1'b0;
    e.name = "direct_s1"; e.ir = 32'h0000EE03; e.v = 1'b1; e.ptr = 3'd0;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut), Valid, 3'(SlotPtr));

    // Start a new word in the assembly buffer.
    @(negedge Clock);
    Direct = 1'b0; I = 8'h10;
    e.name = "direct_asm0"; e.ir = 32'h0000EE03; e.v = 1'b1; e.ptr = 3'd1;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut), Valid, 3'(SlotPtr));

    // Ready is low here, yet the Direct patch still lands.
    @(negedge Clock);
    Direct = 1'b1; Sel = 1'b0; I = 8'hFF;
    #1;
    check("direct_ready_low", 32'(Ready), 32'd0);
    e.name = "direct_s0"; e.ir = 32'h0000EEFF; e.v = 1'b1; e.ptr = 3'd1;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut), Valid, 3'(SlotPtr));

    // The assembly buffer was untouched by the patches.
    @(negedge Clock);
    Direct = 1'b0; I = 8'h20; Take = 1'b1;
    e.name = "direct_complete"; e.ir = 32'h00002010; e.v = 1'b1; e.ptr = 3'd0;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut), Valid, 3'(SlotPtr));
`endif

    @(negedge Clock);
    Write = 1'b0; Take = 1'b0; Flush = 1'b0;

    // SLOTS=4: reset state, then four beats with the pointer walking 1,2,3,0.
    e.name = "s4_reset"; e.ir = 32'h0; e.v = 1'b0; e.ptr = 3'd0;
    sbq.push_back(e);
    checkOutput(IROut4, Valid4, 3'(SlotPtr4));
    for (int b = 1; b <= 4; b++) begin
      @(negedge Clock);
      Reset4 = 1'b1; Write4 = 1'b1; I4 = 8'(b);
      e.name = $sformatf("s4_beat%0d", b);
      e.ir   = (b == 4) ? 32'h04030201 : 32'h0;
      e.v    = (b == 4);
      e.ptr  = 3'(b % 4);
      sbq.push_back(e);
      @(posedge Clock); #1;
      checkOutput(IROut4, Valid4, 3'(SlotPtr4));
    end
    @(negedge Clock);
    Write4 = 1'b0;

    // SLOTS=1: every beat completes; the second one stalls until taken.
    e.name = "s1_reset"; e.ir = 32'h0; e.v = 1'b0; e.ptr = 3'd0;
    sbq.push_back(e);
    checkOutput(32'(IROut1), Valid1, 3'(SlotPtr1));
    Reset1 = 1'b1; Write1 = 1'b1; I1 = 8'h5A;
    #1;
    check("s1_ready_empty", 32'(Ready1), 32'd1);
    e.name = "s1_first"; e.ir = 32'h5A; e.v = 1'b1; e.ptr = 3'd0;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut1), Valid1, 3'(SlotPtr1));
    @(negedge Clock);
    I1 = 8'hC3;
    #1;
    check("s1_ready_stall", 32'(Ready1), 32'd0);
    e.name = "s1_stalled"; e.ir = 32'h5A; e.v = 1'b1; e.ptr = 3'd0;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut1), Valid1, 3'(SlotPtr1));
    @(negedge Clock);
    Take1 = 1'b1;
    #1;
    check("s1_ready_take", 32'(Ready1), 32'd1);
    e.name = "s1_second"; e.ir = 32'hC3; e.v = 1'b1; e.ptr = 3'd0;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut1), Valid1, 3'(SlotPtr1));
    @(negedge Clock);
    Write1 = 1'b0; Take1 = 1'b1;
    e.name = "s1_taken"; e.ir = 32'hC3; e.v = 1'b0; e.ptr = 3'd0;
    sbq.push_back(e);
    @(posedge Clock); #1;
    checkOutput(32'(IROut1), Valid1, 3'(SlotPtr1));

    if (sbq.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
